// File: rtl/prach_pkg.sv
// prach_pkg: shared types and defaults for the PRACH hb1 input scheduler.
//   PRACH_NUM_CH : default number of TDM channels
//   PRACH_CHN_W  : default channel index width
//   sample_t     : signed 16-bit sample
//   pair_t       : polyphase pair (dp1 = newer, dp2 = older, chn)
package prach_pkg;

   localparam int unsigned PRACH_NUM_CH = 16;
   localparam int unsigned PRACH_CHN_W  = 8;

   typedef logic signed [15:0] sample_t;

   typedef struct packed {
      sample_t                dp1;
      sample_t                dp2;
      logic [PRACH_CHN_W-1:0] chn;
   } pair_t;

endpackage : prach_pkg

// File: rtl/prach_hb1_hold_ram.sv
// prach_hb1_hold_ram: per-channel first-sample buffer, DEPTH x 16.
// Registered write, combinational read (distributed RAM friendly).
// Ports:
//   clk      in   clock
//   i_we     in   write enable
//   i_waddr  in   write address (channel)
//   i_wdata  in   sample to store
//   i_raddr  in   read address (channel)
//   o_rdata  out  stored sample at i_raddr
module prach_hb1_hold_ram
   import prach_pkg::*;
#(
   parameter int unsigned DEPTH = PRACH_NUM_CH,
   parameter int unsigned AW    = 4
) (
   input  logic          clk,
   input  logic          i_we,
   input  logic [AW-1:0] i_waddr,
   input  sample_t       i_wdata,
   input  logic [AW-1:0] i_raddr,
   output sample_t       o_rdata
);

   sample_t r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (i_we) begin
         r_mem[i_waddr] <= i_wdata;
      end
   end

   assign o_rdata = r_mem[i_raddr];

endmodule : prach_hb1_hold_ram

// File: rtl/prach_hb1_sched.sv
// prach_hb1_sched: input scheduler for the first half-band decimator.
// Collects two consecutive samples per TDM channel and issues them as a
// polyphase pair (dp1 = newer, dp2 = older) one cycle after the second beat.
// Optional sequence checking is built with PRACH_HB1_SCHED_SEQCHK_EN defined;
// without it err_seq is tied low and err_clr is ignored.
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   cfg_ch_en           channel enable mask, latched at sync
//   din_dq/dv/chn       TDM input sample, valid, channel index
//   sync_in             frame start (with din_dv and din_chn == 0)
//   err_clr             clears sticky err_seq
//   dout_dp1/dp2        pair samples (newer / older)
//   dout_dv, dout_chn   pair valid, pair channel
//   sync_out            first pair after a sync
//   err_seq             sticky sequence error
module prach_hb1_sched
   import prach_pkg::*;
#(
   parameter int unsigned NUM_CH = PRACH_NUM_CH,
   parameter int unsigned CHN_W  = PRACH_CHN_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [NUM_CH-1:0] cfg_ch_en,
   input  sample_t           din_dq,
   input  logic              din_dv,
   input  logic [CHN_W-1:0]  din_chn,
   input  logic              sync_in,
   input  logic              err_clr,
   output sample_t           dout_dp1,
   output sample_t           dout_dp2,
   output logic              dout_dv,
   output logic [CHN_W-1:0]  dout_chn,
   output logic              sync_out,
   output logic              err_seq
);

   localparam int unsigned    AW        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   localparam logic [CHN_W:0] LP_NUM_CH = (CHN_W + 1)'(NUM_CH);

   // global and per-channel state
   logic              r_aligned;
   logic [NUM_CH-1:0] r_en_shadow;
   logic [NUM_CH-1:0] r_phase;
   logic              r_sync_pend;

   // registered outputs
   sample_t           r_dp1;
   sample_t           r_dp2;
   logic              r_dv;
   logic [CHN_W-1:0]  r_chn;
   logic              r_sync_out;

   logic              w_sync;
   logic              w_chn_ok;
   logic [AW-1:0]     w_addr;
   logic [NUM_CH-1:0] w_en_eff;
   logic              w_phase_cur;
   logic              w_accept;
   logic              w_issue;
   logic              w_hold_we;
   logic [NUM_CH-1:0] w_phase_nxt;
   sample_t           w_hold_rd;

   assign w_sync   = din_dv & sync_in & (din_chn == '0);
   assign w_chn_ok = ({1'b0, din_chn} < LP_NUM_CH);
   assign w_addr   = din_chn[AW-1:0];

   // The sync beat is handled as a channel-0 first sample under the new mask
   // and with all phases already cleared, so it sees the post-sync view.
   assign w_en_eff    = w_sync ? cfg_ch_en : r_en_shadow;
   assign w_phase_cur = w_sync ? 1'b0 : r_phase[w_addr];
   assign w_accept    = din_dv & (r_aligned | w_sync) & w_chn_ok & w_en_eff[w_addr];
   assign w_issue     = w_accept & w_phase_cur;
   assign w_hold_we   = w_accept & ~w_phase_cur;

   always_comb begin
      w_phase_nxt = w_sync ? '0 : r_phase;
      if (w_accept) begin
         w_phase_nxt[w_addr] = ~w_phase_cur;
      end
   end

   prach_hb1_hold_ram #(
      .DEPTH (NUM_CH),
      .AW    (AW)
   ) u_hold (
      .clk     (clk),
      .i_we    (w_hold_we),
      .i_waddr (w_addr),
      .i_wdata (din_dq),
      .i_raddr (w_addr),
      .o_rdata (w_hold_rd)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_aligned   <= 1'b0;
         r_en_shadow <= '0;
         r_phase     <= '0;
         r_sync_pend <= 1'b0;
         r_dp1       <= '0;
         r_dp2       <= '0;
         r_dv        <= 1'b0;
         r_chn       <= '0;
         r_sync_out  <= 1'b0;
      end else begin
         r_phase    <= w_phase_nxt;
         r_dv       <= w_issue;
         r_sync_out <= w_issue & r_sync_pend;
         if (w_issue) begin
            r_dp1 <= din_dq;
            r_dp2 <= w_hold_rd;
            r_chn <= din_chn;
         end
         // a sync beat never issues (ch0 phase is forced to 0), so set wins
         if (w_sync) begin
            r_en_shadow <= cfg_ch_en;
            r_aligned   <= 1'b1;
            r_sync_pend <= 1'b1;
         end else if (w_issue) begin
            r_sync_pend <= 1'b0;
         end
      end
   end

   assign dout_dp1 = r_dp1;
   assign dout_dp2 = r_dp2;
   assign dout_dv  = r_dv;
   assign dout_chn = r_chn;
   assign sync_out = r_sync_out;

`ifdef PRACH_HB1_SCHED_SEQCHK_EN
   localparam logic [CHN_W-1:0] LP_LAST     = CHN_W'(NUM_CH - 1);
   localparam logic [CHN_W-1:0] LP_AFTER_S0 = (NUM_CH > 1) ? CHN_W'(1) : '0;

   logic [CHN_W-1:0] r_exp_chn;
   logic             r_err;
   logic             w_err_evt;

   // A valid sync beat redefines frame position, so it is not itself
   // compared against exp_chn.
   assign w_err_evt = din_dv & (
                         (r_aligned & ~w_sync & (din_chn != r_exp_chn)) |
                         ~w_chn_ok |
                         (sync_in & (din_chn != '0)));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_exp_chn <= '0;
         r_err     <= 1'b0;
      end else begin
         if (din_dv) begin
            if (w_sync) begin
               r_exp_chn <= LP_AFTER_S0;
            end else if (r_exp_chn == LP_LAST) begin
               r_exp_chn <= '0;
            end else begin
               r_exp_chn <= r_exp_chn + CHN_W'(1);
            end
         end
         if (w_err_evt) begin
            r_err <= 1'b1;
         end else if (err_clr) begin
            r_err <= 1'b0;
         end
      end
   end

   assign err_seq = r_err;
`else
   logic w_unused_err_clr;
   assign w_unused_err_clr = err_clr;
   assign err_seq          = 1'b0;
`endif

endmodule : prach_hb1_sched

// File: tb/tb_prach_hb1_sched.sv
// tb_prach_hb1_sched: scoreboard bench for prach_hb1_sched.
// Stimulus pushes hand-computed pairs into a queue; a monitor on the falling
// edge pops and compares each presented pair, including its issue cycle.
module tb_prach_hb1_sched;

`ifdef PRACH_HB1_SCHED_SEQCHK_EN
   localparam int SEQ = 1;
`else
   localparam int SEQ = 0;
`endif

   logic               clk = 1'b0;
   logic               rst = 1'b1;
   logic [15:0]        cfg_ch_en = '0;
   logic signed [15:0] din_dq = '0;
   logic               din_dv = 1'b0;
   logic [7:0]         din_chn = '0;
   logic               sync_in = 1'b0;
   logic               err_clr = 1'b0;
   logic signed [15:0] dout_dp1;
   logic signed [15:0] dout_dp2;
   logic               dout_dv;
   logic [7:0]         dout_chn;
   logic               sync_out;
   logic               err_seq;

   prach_hb1_sched #(.NUM_CH(16), .CHN_W(8)) dut (
      .clk       (clk),
      .rst       (rst),
      .cfg_ch_en (cfg_ch_en),
      .din_dq    (din_dq),
      .din_dv    (din_dv),
      .din_chn   (din_chn),
      .sync_in   (sync_in),
      .err_clr   (err_clr),
      .dout_dp1  (dout_dp1),
      .dout_dp2  (dout_dp2),
      .dout_dv   (dout_dv),
      .dout_chn  (dout_chn),
      .sync_out  (sync_out),
      .err_seq   (err_seq)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc++;

   typedef struct {
      logic [15:0] dp1;
      logic [15:0] dp2;
      logic [7:0]  chn;
      logic        sy;
      int          cyc;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   errors = 0;

   // monitor
   always @(negedge clk) begin
      if (sync_out && !dout_dv) begin
         checks++;
         errors++;
         $display("FAIL sync_alone: sync_out=1 with dout_dv=0 at cycle %0d, required sync_out only with dv", cyc);
      end
      if (dout_dv) begin
         checks++;
         if (q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_pair: got dp1=%0d dp2=%0d chn=%0d at cycle %0d, required no output",
                     dout_dp1, dout_dp2, dout_chn, cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            if (dout_dp1 !== e.dp1 || dout_dp2 !== e.dp2 || dout_chn !== e.chn ||
                sync_out !== e.sy || cyc != e.cyc) begin
               errors++;
               $display("FAIL pair: got dp1=%0d dp2=%0d chn=%0d sync=%0b cyc=%0d, required dp1=%0d dp2=%0d chn=%0d sync=%0b cyc=%0d",
                        dout_dp1, dout_dp2, dout_chn, sync_out, cyc, e.dp1, e.dp2, e.chn, e.sy, e.cyc);
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, exp);
      end
   endtask

   task automatic beat(input int ch, input int dq, input bit sy);
      @(posedge clk);
      #1;
      din_dv  = 1'b1;
      din_chn = ch[7:0];
      din_dq  = dq[15:0];
      sync_in = sy;
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
         din_dv  = 1'b0;
         sync_in = 1'b0;
      end
   endtask

   // called right after the second beat is driven: output due next cycle
   task automatic expect_pair(input int dp1, input int dp2, input int ch, input bit sy);
      exp_t e;
      e.dp1 = dp1[15:0];
      e.dp2 = dp2[15:0];
      e.chn = ch[7:0];
      e.sy  = sy;
      e.cyc = cyc + 1;
      q.push_back(e);
   endtask

   task automatic pulse_err_clr();
      @(posedge clk);
      #1;
      din_dv  = 1'b0;
      err_clr = 1'b1;
      @(posedge clk);
      #1;
      err_clr = 1'b0;
   endtask

   initial begin
      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_dv", int'(dout_dv), 0);
      chk("rst_dp1", int'(dout_dp1), 0);
      chk("rst_dp2", int'(dout_dp2), 0);
      chk("rst_chn", int'(dout_chn), 0);
      chk("rst_sync", int'(sync_out), 0);
      chk("rst_err", int'(err_seq), 0);
      rst = 1'b0;
      cfg_ch_en = 16'hFFFF;

      // pre-sync drop: two frames, nothing may come out
      for (int f = 0; f < 2; f++)
         for (int i = 0; i < 16; i++) beat(i, 50 + i, 1'b0);
      idle(3);

      // basic pairing
      for (int i = 0; i < 16; i++) beat(i, 100 + i, i == 0);
      for (int i = 0; i < 16; i++) begin
         beat(i, 200 + i, 1'b0);
         expect_pair(200 + i, 100 + i, i, i == 0);
      end
      idle(3);
      chk("hold_dp1", int'(dout_dp1), 215);
      chk("hold_dp2", int'(dout_dp2), 115);
      chk("hold_chn", int'(dout_chn), 15);
      chk("hold_dv", int'(dout_dv), 0);

      // mask 0x0005, mid-frame change to 0xFFFF ignored until next sync
      cfg_ch_en = 16'h0005;
      for (int i = 0; i < 16; i++) beat(i, 10 + i, i == 0);
      for (int i = 0; i < 16; i++) begin
         if (i == 8) cfg_ch_en = 16'hFFFF;
         beat(i, 20 + i, 1'b0);
         if (i == 0 || i == 2) expect_pair(20 + i, 10 + i, i, i == 0);
      end
      for (int i = 0; i < 16; i++) beat(i, 30 + i, 1'b0);
      for (int i = 0; i < 16; i++) begin
         beat(i, 40 + i, 1'b0);
         if (i == 0 || i == 2) expect_pair(40 + i, 30 + i, i, 1'b0);
      end
      idle(2);

      // resync with every channel holding a first sample
      for (int i = 0; i < 16; i++) beat(i, 300 + i, i == 0);
      for (int i = 0; i < 16; i++) beat(i, 400 + i, i == 0);
      for (int i = 0; i < 16; i++) begin
         beat(i, 500 + i, 1'b0);
         expect_pair(500 + i, 400 + i, i, i == 0);
      end
      idle(2);
      pulse_err_clr();
      chk("err_clean", int'(err_seq), 0);

      // sequence check: skip ch5
      for (int i = 0; i < 16; i++) beat(i, 600 + i, i == 0);
      for (int i = 0; i < 5; i++) begin
         beat(i, 700 + i, 1'b0);
         expect_pair(700 + i, 600 + i, i, i == 0);
      end
      beat(6, 706, 1'b0);
      expect_pair(706, 606, 6, 1'b0);
      chk("err_before_skip", int'(err_seq), 0);
      beat(7, 707, 1'b0);
      expect_pair(707, 607, 7, 1'b0);
      chk("err_after_skip", int'(err_seq), SEQ);
      for (int i = 8; i < 16; i++) begin
         beat(i, 700 + i, 1'b0);
         expect_pair(700 + i, 600 + i, i, 1'b0);
      end
      idle(3);
      chk("err_sticky", int'(err_seq), SEQ);
      pulse_err_clr();
      chk("err_cleared", int'(err_seq), 0);

      // out-of-range channel: dropped, flagged when checking is built
      beat(20, 999, 1'b0);
      idle(1);
      chk("err_range", int'(err_seq), SEQ);
      pulse_err_clr();
      chk("err_range_clr", int'(err_seq), 0);

      // reset with phase bits set (ch0..3 fresh, ch5 still holding 605)
      for (int i = 0; i < 4; i++) beat(i, 1000 + i, 1'b0);
      @(posedge clk);
      #1;
      din_dv = 1'b0;
      rst    = 1'b1;
      @(posedge clk);
      #1;
      chk("mid_rst_dv", int'(dout_dv), 0);
      chk("mid_rst_dp1", int'(dout_dp1), 0);
      chk("mid_rst_dp2", int'(dout_dp2), 0);
      chk("mid_rst_chn", int'(dout_chn), 0);
      rst = 1'b0;
      for (int i = 0; i < 16; i++) beat(i, 1100 + i, 1'b0);
      for (int i = 0; i < 16; i++) beat(i, 800 + i, i == 0);
      for (int i = 0; i < 16; i++) begin
         beat(i, 900 + i, 1'b0);
         expect_pair(900 + i, 800 + i, i, i == 0);
      end
      idle(5);
      chk("scoreboard_drained", q.size(), 0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not complete, required completion");
      $fatal(1);
   end

endmodule : tb_prach_hb1_sched
